// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
// Instruction-fetch controller for a combinational instruction ROM.
// Owns the fetch PC, drives the ROM word address, captures each returned
// instruction into a 2-entry fetch buffer and hands instructions to decode
// over a valid/ready handshake. Execute-stage redirects flush the buffer
// and reload the fetch PC.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   en_i           fetch enable (low = no new fetches, buffer still drains)
//   rom_addr_o     ROM word address (fetch_pc[ROM_AW+1:2])
//   rom_inst_i     ROM data, valid in the same cycle as rom_addr_o
//   redirect_i     flush buffer and load redirect_pc_i
//   redirect_pc_i  redirect target byte address (low 2 bits ignored)
//   inst_valid_o   buffer head valid
//   inst_o         head instruction (NOP_INST when empty)
//   inst_pc_o      byte PC of head instruction (0 when empty)
//   inst_ready_i   decode accepts head this cycle
//   fetch_pc_o     current fetch PC
// ---------------------------------------------------------------------------
module if_fetch_ctrl #(
  parameter int                PC_W     = 32,
  parameter int                ROM_AW   = 8,
  parameter logic [PC_W-1:0]   RESET_PC = 32'h0000_0000,
  parameter logic [31:0]       NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [31:0]       rom_inst_i,
  input  logic              redirect_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic [PC_W-1:0]   inst_pc_o,
  input  logic              inst_ready_i,
  output logic [PC_W-1:0]   fetch_pc_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_t;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_fetch_pc;
  logic [1:0]        r_count;
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [31:0]       r_inst [2];
  logic [PC_W-1:0]   r_pc   [2];

  logic              w_pop;
  logic              w_push;
  logic [PC_W-1:0]   w_redirect_pc;
  logic              w_unused_pc_lsb;

  // Redirect targets are word aligned; the dropped low bits are intentionally ignored.
  assign w_redirect_pc   = {redirect_pc_i[PC_W-1:2], 2'b00};
  assign w_unused_pc_lsb = ^redirect_pc_i[1:0];

  // A full buffer may still accept a fetch when the head leaves in the same cycle.
  assign w_pop  = (r_count != 2'd0) & inst_ready_i;
  assign w_push = (r_state == ST_FETCH) & en_i & ~redirect_i &
                  ((r_count < 2'd2) | w_pop);

  // ROM address simply truncates the fetch PC, so high PCs alias to low words.
  assign rom_addr_o = r_fetch_pc[ROM_AW+1:2];
  assign fetch_pc_o = r_fetch_pc;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; redirects never change state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (en_i) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (!en_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Fetch PC, buffer pointers, occupancy and buffer storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_count    <= 2'd0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_inst[0]  <= 32'h0000_0000;
      r_inst[1]  <= 32'h0000_0000;
      r_pc[0]    <= '0;
      r_pc[1]    <= '0;
    end else if (redirect_i) begin
      // A coincident pop has already been seen by decode this cycle; the
      // remaining entries are stale and simply discarded.
      r_fetch_pc <= w_redirect_pc;
      r_count    <= 2'd0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
    end else begin
      if (w_push) begin
        r_inst[r_wr_ptr] <= rom_inst_i;
        r_pc[r_wr_ptr]   <= r_fetch_pc;
        r_wr_ptr         <= ~r_wr_ptr;
        r_fetch_pc       <= r_fetch_pc + PC_STEP;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head-of-buffer presentation; an empty buffer shows a NOP at PC 0.
  always_comb begin
    inst_valid_o = 1'b0;
    inst_o       = NOP_INST;
    inst_pc_o    = '0;
    if (r_count != 2'd0) begin
      inst_valid_o = 1'b1;
      inst_o       = r_inst[r_rd_ptr];
      inst_pc_o    = r_pc[r_rd_ptr];
    end else begin
      inst_valid_o = 1'b0;
      inst_o       = NOP_INST;
      inst_pc_o    = '0;
    end
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch controller for the core's combinational instruction ROM. Owns the fetch PC, drives the ROM word address and captures each returned instruction into a 2-entry fetch buffer. Presents instructions to decode over a valid/ready handshake. Accepts branch/jump redirects from execute, which flush the buffer.

Parameters:
PC_W, 32, width of PC and instruction-address bus (InstAddrBus)
ROM_AW, 8, ROM word-address width; rom_addr_o = fetch_pc[ROM_AW+1:2]
RESET_PC, 32'h0000_0000, fetch PC after reset
NOP_INST, 32'h0000_0013, value on inst_o when buffer empty (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
en_i  in  1  fetch enable; low = stop issuing new fetches
rom_addr_o  out  ROM_AW  word address to ROM (combinational from fetch_pc)
rom_inst_i  in  32  ROM data, valid same cycle as rom_addr_o
redirect_i  in  1  flush and load new PC
redirect_pc_i  in  PC_W  redirect target (byte address)
inst_valid_o  out  1  buffer head valid
inst_o  out  32  head instruction (InstBus)
inst_pc_o  out  PC_W  byte PC of head instruction
inst_ready_i  in  1  decode accepts head this cycle
fetch_pc_o  out  PC_W  current fetch PC (debug/visibility)

Behaviour:
- Reset (async assert, sync-released use): fetch_pc=RESET_PC, state=IDLE, count=0, rd/wr ptr=0; inst_valid_o=0, inst_o=NOP_INST, inst_pc_o=0, fetch_pc_o=RESET_PC, rom_addr_o=RESET_PC[ROM_AW+1:2].
- FSM: IDLE (no fetch) -> FETCH when en_i=1; FETCH -> IDLE when en_i=0. Redirect is legal in both states and does not change state.
- pop = inst_valid_o & inst_ready_i.
- push = (state==FETCH) & en_i & ~redirect_i & (count<2 | pop). Full buffer with simultaneous pop: push allowed (throughput 1 inst/cycle).
- On push: entry[wr_ptr] <= {fetch_pc, rom_inst_i}; wr_ptr toggles; fetch_pc <= fetch_pc + 4 (mod 2^PC_W).
- No push: fetch_pc holds; ROM address stays stable.
- count' = count + push - pop; range 0..2; count never exceeds 2 or underflows.
- Redirect (highest priority): count<=0, pointers<=0, fetch_pc <= {redirect_pc_i[PC_W-1:2], 2'b00} (misaligned low bits dropped); no push that cycle. A pop coincident with redirect still completes for decode (head handed over), but the buffer is cleared anyway. First fetch from target occurs next cycle; target inst visible on inst_valid_o 1 cycle after redirect (latency: redirect edge N, push edge N+1, valid after N+1).
- Fetch latency from FETCH entry: first instruction valid 1 cycle after first push edge.
- Outputs: inst_valid_o = (count!=0); when count==0, inst_o=NOP_INST, inst_pc_o=0; else head entry. Head stable while valid & ~ready.
- ROM address wrap: rom_addr_o truncates fetch_pc; PC beyond 4*2^ROM_AW aliases to low ROM words; no error flagged.
- en_i falling: in-flight buffer contents retained and drainable; fetch_pc holds.
- Reset mid-operation: immediate return to reset values; buffered instructions discarded.

Test Plan:
- Reset then en_i=1, inst_ready_i=1, ROM model returns 32'hA000_0000|word_idx -> inst_o sequence A0000000,A0000001,A0000002 with inst_pc_o 0,4,8, one per cycle, no bubbles after first.
- en_i=1, inst_ready_i=0 for 5 cycles -> count saturates at 2, fetch_pc_o stops at 8, head holds A0000000/pc 0; release ready -> A0000000, A0000001, A0000002 in order, none lost/duplicated.
- Buffer full, redirect_i=1 with redirect_pc_i=32'h0000_0043 -> next cycle inst_valid_o=0, inst_o=NOP_INST; following cycle inst_o=A0000010, inst_pc_o=32'h40.
- Redirect coincident with full-buffer pop -> exactly one instruction (old head) accepted, all older entries dropped, no push that cycle.
- fetch_pc = 32'h0000_03FC then advance -> rom_addr_o goes 8'hFF then 8'h00, inst_pc_o=32'h400 for wrapped fetch.
- rst_n asserted low mid-stream with count=2 -> inst_valid_o=0, fetch_pc_o=RESET_PC asynchronously; after release and en_i=1, stream restarts at pc 0.
